pong_match_fsm: RTL and testbench
=================================

Name: pong_match_fsm

Overview:
- Parametrised match controller for the Pong design: tracks per-player scores, serve delay, pause and game-over for 2..4 players.
- Sits between the ball/paddle engine, which reports misses and consumes stop/ball_reset, and the display blocks (dot matrix, seven-segment timer), which consume the scores, state and timer enable.
- Successor to the fixed two-player new_game/play/new_ball/over flow. Adds configurable player count, win score and serve delay, plus pause, winner reporting and simultaneous-miss handling.

Parameters:
- N_PLAYERS, 2, number of players (2..4)
- SCORE_W, 3, score width per player in bits
- WIN_SCORE, 5, score that ends the match (1..2^SCORE_W-1)
- SERVE_TICKS, 2, tick pulses waited before a serve
- TICK_CNT_W, 4, width of the serve-delay counter (must hold SERVE_TICKS)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tick  in  1  one-cycle enable pulse (e.g. 1 Hz) used for serve delay
- start  in  1  start/restart request, level; rising edge detected internally
- pause  in  1  pause toggle request, level; rising edge detected internally
- miss  in  N_PLAYERS  bit i = ball passed player i's paddle this cycle (pulse)
- state  out  3  current state encoding (see Behaviour)
- scores  out  N_PLAYERS*SCORE_W  packed scores, player i at [i*SCORE_W +: SCORE_W]
- stop  out  1  1 = freeze ball/paddle engine
- ball_reset  out  1  one-cycle pulse: recentre ball and serve
- serve_player  out  2  player serving next
- timer_en  out  1  run the match timer (high only in PLAY)
- winner  out  2  winning player index, valid when game_over=1
- game_over  out  1  high in OVER

Behaviour:
- Reset (async, rst=1): state=IDLE, scores=0, stop=1, ball_reset=0, serve_player=0, timer_en=0, winner=0, game_over=0, serve counter=0, edge-detect registers=0.
- States: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, OVER=4. All outputs registered; they change on the clk edge after the causing input.
- start_p = start & ~start_d, and pause_p likewise. The _d registers sample every cycle.
- IDLE:
  - start_p: scores cleared, serve counter cleared, go to SERVE.
- SERVE:
  - stop=1.
  - On tick, counter increments.
  - When counter reaches SERVE_TICKS: go to PLAY, ball_reset=1 for exactly that one cycle, counter cleared.
  - SERVE_TICKS=0: leave after one cycle.
  - pause and miss ignored.
- PLAY:
  - stop=0, timer_en=1.
  - miss!=0: every player j with miss[j]=0 gains +1. Scores saturate at WIN_SCORE.
  - serve_player = lowest set index of miss.
  - Next state: if any updated score equals WIN_SCORE, go to OVER, with winner = lowest such index. Otherwise go to SERVE.
  - All players missing together: no score change, go to SERVE, serve_player = 0.
  - miss and pause_p in the same cycle: miss wins, pause dropped.
- PAUSED:
  - stop=1, timer_en=0.
  - pause_p returns to PLAY, with no ball_reset.
  - miss ignored.
  - start_p restarts the match: scores cleared, go to SERVE.
- OVER:
  - stop=1, game_over=1; winner and scores held.
  - start_p: scores cleared, winner=0, go to SERVE.
- start_p in SERVE or PLAY is ignored.
- Unused encodings 5..7 return to IDLE.
- tick arriving in the same cycle as a state entry into SERVE is not counted.

Decomposition:
- Shared package pong_pkg holds:
  - state encodings (IDLE..OVER)
  - MAX_PLAYERS=4
  - the default WIN_SCORE/SERVE_TICKS constants, shared with dot_matrix and graphics blocks
- One natural sub-module, pong_edge_detect (parametrised width, registered rising-edge pulse), used for start and pause.
- The score array stays in the top as a generate loop.

Test Plan:
1. Reset then start rising edge with N=2, SERVE_TICKS=2 -> state SERVE; after 2 ticks, state PLAY, ball_reset high exactly 1 cycle, stop=0.
2. PLAY with miss=2'b01 -> scores player1=1, player0=0, serve_player=0, state SERVE, stop=1.
3. N=2, WIN_SCORE=5, player0 at 4, miss=2'b10 -> player0=5, state OVER, winner=0, game_over=1. Further misses leave scores unchanged. start_p -> scores 0, state SERVE.
4. PLAY then pause rising edge -> PAUSED, timer_en=0, miss=2'b01 ignored. Second pause edge -> PLAY, no ball_reset. pause and miss in same cycle in PLAY -> miss scored, state SERVE.
5. N=4, miss=4'b0101 -> players 1 and 3 +1, players 0 and 2 unchanged, serve_player=0. miss=4'b1111 -> no change.
6. Assert rst mid-SERVE with counter=1 -> immediately IDLE, scores 0, all outputs at reset values. Holding start high after rst deasserts does not start a match until start falls and rises again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong design: match state encodings, player
// limits and the default match constants used by the display blocks.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam int MAX_PLAYERS         = 4;
    localparam int DEFAULT_WIN_SCORE   = 5;
    localparam int DEFAULT_SERVE_TICKS = 2;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [1:0] lowest_set(input logic [MAX_PLAYERS-1:0] v);
        lowest_set = 2'd0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/pong_match_fsm_if.sv
// Match controller bus: engine/timer requests in, score/state/status out.
interface pong_match_fsm_if
    import pong_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 3
);
    logic                           tick;
    logic                           start;
    logic                           pause;
    logic [N_PLAYERS-1:0]           miss;
    logic [2:0]                     state;
    logic [N_PLAYERS*SCORE_W-1:0]   scores;
    logic                           stop;
    logic                           ball_reset;
    logic [1:0]                     serve_player;
    logic                           timer_en;
    logic [1:0]                     winner;
    logic                           game_over;

    // Side that issues requests and consumes match status.
    modport master (
        output tick, start, pause, miss,
        input  state, scores, stop, ball_reset, serve_player, timer_en, winner, game_over
    );

    // Match controller side.
    modport slave (
        input  tick, start, pause, miss,
        output state, scores, stop, ball_reset, serve_player, timer_en, winner, game_over
    );
endinterface

// File: rtl/pong_edge_detect.sv
// Rising-edge detector: the previous level is held in a register and the
// pulse is high for the single cycle where the level goes 0 -> 1.
module pong_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse
);
    logic [WIDTH-1:0] level_d;

    // Sample the input level every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= '0;
        end else begin
            level_d <= level;
        end
    end

    assign pulse = level & ~level_d;
endmodule

// File: rtl/pong_match_fsm.sv
// Pong match controller: serve delay, play, pause and game-over sequencing
// with per-player scoring for 2..4 players. All outputs are registered.
module pong_match_fsm
    import pong_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
    parameter int SERVE_TICKS = DEFAULT_SERVE_TICKS,
    parameter int TICK_CNT_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    pong_match_fsm_if.slave bus
);
    localparam logic [SCORE_W-1:0]    WIN_VAL     = SCORE_W'(WIN_SCORE);
    localparam logic [TICK_CNT_W-1:0] SERVE_LIMIT = TICK_CNT_W'(SERVE_TICKS);

    logic [1:0]             edges;
    logic                   start_p;
    logic                   pause_p;
    state_t                 state_reg;
    logic [TICK_CNT_W-1:0]  cnt_reg;
    logic [TICK_CNT_W-1:0]  cnt_next;
    logic                   stop_reg;
    logic                   ball_reset_reg;
    logic [1:0]             serve_player_reg;
    logic                   timer_en_reg;
    logic [1:0]             winner_reg;
    logic                   game_over_reg;
    logic                   any_miss;
    logic                   score_clr;
    logic                   score_upd;
    logic [N_PLAYERS-1:0]   win_hit;

    pong_edge_detect #(.WIDTH(2)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .level ({bus.pause, bus.start}),
        .pulse (edges)
    );

    assign start_p  = edges[0];
    assign pause_p  = edges[1];
    assign any_miss = |bus.miss;
    assign cnt_next = cnt_reg + 1'b1;

    // A restart is honoured only where start_p leads to a fresh match.
    assign score_clr = start_p && (state_reg == ST_IDLE || state_reg == ST_PAUSED ||
                                   state_reg == ST_OVER);
    assign score_upd = (state_reg == ST_PLAY) && any_miss;

    // Per-player score: every player who did not miss gains a point,
    // saturating at the winning score.
    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_score
            logic [SCORE_W-1:0] score_reg;
            logic [SCORE_W-1:0] score_inc;

            assign score_inc = (!bus.miss[gi] && score_reg < WIN_VAL) ?
                               score_reg + 1'b1 : score_reg;
            assign win_hit[gi] = (score_inc == WIN_VAL);
            assign bus.scores[gi*SCORE_W +: SCORE_W] = score_reg;

            // Score register: cleared on a new match, bumped on a miss in PLAY.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    score_reg <= '0;
                end else if (score_clr) begin
                    score_reg <= '0;
                end else if (score_upd) begin
                    score_reg <= score_inc;
                end
            end
        end
    endgenerate

    // Match sequencing with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            stop_reg         <= 1'b1;
            ball_reset_reg   <= 1'b0;
            serve_player_reg <= 2'd0;
            timer_en_reg     <= 1'b0;
            winner_reg       <= 2'd0;
            game_over_reg    <= 1'b0;
        end else begin
            ball_reset_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_p) begin
                        state_reg <= ST_SERVE;
                        cnt_reg   <= '0;
                        stop_reg  <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    // The count reaching the limit on this tick launches the ball;
                    // a zero limit launches after a single cycle in SERVE.
                    if (SERVE_LIMIT == '0 || (bus.tick && cnt_next == SERVE_LIMIT)) begin
                        state_reg      <= ST_PLAY;
                        ball_reset_reg <= 1'b1;
                        cnt_reg        <= '0;
                        stop_reg       <= 1'b0;
                        timer_en_reg   <= 1'b1;
                    end else if (bus.tick) begin
                        cnt_reg <= cnt_next;
                    end
                end
                ST_PLAY: begin
                    if (any_miss) begin
                        serve_player_reg <= lowest_set(MAX_PLAYERS'(bus.miss));
                        stop_reg         <= 1'b1;
                        timer_en_reg     <= 1'b0;
                        if (|win_hit) begin
                            state_reg     <= ST_OVER;
                            winner_reg    <= lowest_set(MAX_PLAYERS'(win_hit));
                            game_over_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SERVE;
                            cnt_reg   <= '0;
                        end
                    end else if (pause_p) begin
                        state_reg    <= ST_PAUSED;
                        stop_reg     <= 1'b1;
                        timer_en_reg <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (start_p) begin
                        state_reg <= ST_SERVE;
                        cnt_reg   <= '0;
                    end else if (pause_p) begin
                        state_reg    <= ST_PLAY;
                        stop_reg     <= 1'b0;
                        timer_en_reg <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (start_p) begin
                        state_reg     <= ST_SERVE;
                        cnt_reg       <= '0;
                        winner_reg    <= 2'd0;
                        game_over_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= '0;
                    stop_reg      <= 1'b1;
                    timer_en_reg  <= 1'b0;
                    winner_reg    <= 2'd0;
                    game_over_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state        = state_reg;
    assign bus.stop         = stop_reg;
    assign bus.ball_reset   = ball_reset_reg;
    assign bus.serve_player = serve_player_reg;
    assign bus.timer_en     = timer_en_reg;
    assign bus.winner       = winner_reg;
    assign bus.game_over    = game_over_reg;
endmodule

// File: tb/tb_pong_match_fsm.sv
// Testbench for pong_match_fsm: a 2-player and a 4-player instance driven
// step by step; expected outputs are queued with each stimulus and popped
// after the clock edge.
module tb_pong_match_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pong_match_fsm_if #(.N_PLAYERS(2), .SCORE_W(3)) b2 ();
    pong_match_fsm_if #(.N_PLAYERS(4), .SCORE_W(3)) b4 ();

    pong_match_fsm #(.N_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(5), .SERVE_TICKS(2), .TICK_CNT_W(4))
        dut2 (.clk(clk), .rst(rst), .bus(b2));
    pong_match_fsm #(.N_PLAYERS(4), .SCORE_W(3), .WIN_SCORE(5), .SERVE_TICKS(2), .TICK_CNT_W(4))
        dut4 (.clk(clk), .rst(rst), .bus(b4));

    typedef struct {
        logic [2:0]  state;
        logic [15:0] sc;
        logic        stop;
        logic        br;
        logic [1:0]  sv;
        logic        te;
        logic [1:0]  w;
        logic        go;
    } out_t;

    typedef struct {
        string tag;
        bit    sel;
        out_t  exp;
    } sb_t;

    sb_t  sb[$];
    out_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic out_t grab(input bit sel);
        out_t o;
        if (sel) begin
            o = '{b4.state, 16'(b4.scores), b4.stop, b4.ball_reset, b4.serve_player,
                  b4.timer_en, b4.winner, b4.game_over};
        end else begin
            o = '{b2.state, 16'(b2.scores), b2.stop, b2.ball_reset, b2.serve_player,
                  b2.timer_en, b2.winner, b2.game_over};
        end
        return o;
    endfunction

    task automatic compare(input string tag, input out_t o, input out_t x);
        check_val({tag, ".state"}, 16'(o.state), 16'(x.state));
        check_val({tag, ".scores"}, o.sc, x.sc);
        check_val({tag, ".stop"}, 16'(o.stop), 16'(x.stop));
        check_val({tag, ".ball_reset"}, 16'(o.br), 16'(x.br));
        check_val({tag, ".serve"}, 16'(o.sv), 16'(x.sv));
        check_val({tag, ".timer_en"}, 16'(o.te), 16'(x.te));
        check_val({tag, ".winner"}, 16'(o.w), 16'(x.w));
        check_val({tag, ".game_over"}, 16'(o.go), 16'(x.go));
    endtask

    task automatic reset_exp();
        e = '{3'd0, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
    endtask

    // One clock of stimulus on the selected instance; the other sits idle.
    task automatic step(input string tag, input bit sel, input logic t, input logic s,
                        input logic p, input logic [3:0] m);
        sb_t   item;
        out_t  o;
        @(negedge clk);
        b2.tick = sel ? 1'b0 : t;   b4.tick = sel ? t : 1'b0;
        b2.start = sel ? 1'b0 : s;  b4.start = sel ? s : 1'b0;
        b2.pause = sel ? 1'b0 : p;  b4.pause = sel ? p : 1'b0;
        b2.miss = sel ? 2'b00 : m[1:0];
        b4.miss = sel ? m : 4'b0000;
        sb.push_back('{tag, sel, e});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, ".scoreboard_empty"}, 16'd0, 16'd1);
        end else begin
            item = sb.pop_front();
            o = grab(item.sel);
            $display("STEP %-14s dut%0d state=%0d scores=%0h stop=%0b br=%0b serve=%0d win=%0d go=%0b",
                     item.tag, item.sel ? 4 : 2, o.state, o.sc, o.stop, o.br, o.sv, o.w, o.go);
            compare(item.tag, o, item.exp);
        end
    endtask

    // SERVE with two ticks (a miss in between is ignored), then launch.
    task automatic to_play(input string tag, input bit sel);
        e.state = 3'd1; e.stop = 1'b1; e.te = 1'b0; e.br = 1'b0;
        step({tag, "_t1"}, sel, 1'b1, 1'b0, 1'b0, 4'b0000);
        step({tag, "_gap"}, sel, 1'b0, 1'b0, 1'b0, 4'b0001);
        e.state = 3'd2; e.stop = 1'b0; e.te = 1'b1; e.br = 1'b1;
        step({tag, "_t2"}, sel, 1'b1, 1'b0, 1'b0, 4'b0000);
        e.br = 1'b0;
        step({tag, "_play"}, sel, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        reset_exp();
        compare({tag, "_d2"}, grab(1'b0), e);
        compare({tag, "_d4"}, grab(1'b1), e);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        b2.tick = 0; b2.start = 0; b2.pause = 0; b2.miss = '0;
        b4.tick = 0; b4.start = 0; b4.pause = 0; b4.miss = '0;
        reset_exp();
        @(posedge clk);
        @(posedge clk);
        do_reset("reset");

        // Start, serve delay and launch.
        e.state = 3'd1;
        step("start", 0, 1'b0, 1'b1, 1'b0, 4'b0000);
        to_play("serve1", 0);

        // Player 0 misses: player 1 scores.
        e = '{3'd1, 16'd8, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        step("miss01", 0, 1'b0, 1'b0, 1'b0, 4'b0001);

        // Player 1 misses four times: player 0 climbs to 4.
        for (int k = 1; k <= 4; k++) begin
            to_play("serve", 0);
            e = '{3'd1, 16'(8 + k), 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0};
            step("miss10", 0, 1'b0, 1'b0, 1'b0, 4'b0010);
        end
        to_play("serve_w", 0);
        e = '{3'd4, 16'd13, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b1};
        step("win", 0, 1'b0, 1'b0, 1'b0, 4'b0010);
        step("over_miss", 0, 1'b0, 1'b0, 1'b0, 4'b0001);
        e = '{3'd1, 16'd0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0};
        step("restart", 0, 1'b0, 1'b1, 1'b0, 4'b0000);

        // Pause / resume, miss ignored while paused.
        to_play("serve_p", 0);
        e.state = 3'd3; e.stop = 1'b1; e.te = 1'b0;
        step("pause", 0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step("paused_miss", 0, 1'b0, 1'b0, 1'b1, 4'b0001);
        step("pause_low", 0, 1'b0, 1'b0, 1'b0, 4'b0000);
        e.state = 3'd2; e.stop = 1'b0; e.te = 1'b1;
        step("resume", 0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step("resume_low", 0, 1'b0, 1'b0, 1'b0, 4'b0000);
        e = '{3'd1, 16'd8, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        step("pause_miss", 0, 1'b0, 1'b0, 1'b1, 4'b0001);

        // Reset in SERVE with the counter at 1.
        step("serve_cnt1", 0, 1'b1, 1'b0, 1'b0, 4'b0000);
        do_reset("mid_rst");
        e.state = 3'd1;
        step("start2", 0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step("start_hold1", 0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step("start_hold2", 0, 1'b0, 1'b1, 1'b0, 4'b0000);
        to_play("serve_r", 0);

        // Restart from PAUSED.
        e = '{3'd1, 16'd8, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        step("miss01b", 0, 1'b0, 1'b0, 1'b0, 4'b0001);
        to_play("serve_q", 0);
        e.state = 3'd3; e.stop = 1'b1; e.te = 1'b0;
        step("pause2", 0, 1'b0, 1'b0, 1'b1, 4'b0000);
        e.state = 3'd1; e.sc = 16'd0;
        step("paused_start", 0, 1'b0, 1'b1, 1'b0, 4'b0000);

        // Four-player instance.
        do_reset("reset4");
        e.state = 3'd1;
        step("start4", 1, 1'b0, 1'b1, 1'b0, 4'b0000);
        to_play("serve4a", 1);
        e = '{3'd1, 16'd520, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        step("miss0101", 1, 1'b0, 1'b0, 1'b0, 4'b0101);
        to_play("serve4b", 1);
        e = '{3'd1, 16'd520, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        step("miss1111", 1, 1'b0, 1'b0, 1'b0, 4'b1111);
        to_play("serve4c", 1);
        e = '{3'd1, 16'd529, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0};
        step("miss1100", 1, 1'b0, 1'b0, 1'b0, 4'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
